// File: rtl/dfifo_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO family.
package dfifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Widest legal level/threshold; narrower levels are zero-extended into it for comparison.
  localparam int MAX_ADDR_WIDTH = 10;
  typedef logic [MAX_ADDR_WIDTH:0] level_max_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dfifo_sync_lvl_if.sv
// Write/read/status bundle of dfifo_sync_lvl; master is the user, slave is the FIFO.
interface dfifo_sync_lvl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 256
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
    input  full, almost_full, rd_data, empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
    output full, almost_full, rd_data, empty, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/dfifo_dpram.sv
// DEPTH x DATA_WIDTH distributed RAM: synchronous write, asynchronous read.
module dfifo_dpram
  import dfifo_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 256,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dfifo_sync_lvl.sv
// Single-clock FIFO with programmable thresholds and fill level; DFIFO_SYNC_LVL_STATS_EN adds ovf/unf counters.
// Flags registered from next-state level; rd_data 1-cycle (std) or fall-through; full drops writes, empty drops reads.
module dfifo_sync_lvl
  import dfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 256,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input logic clk,
  input logic rst,
  dfifo_sync_lvl_if.slave fif
`ifdef DFIFO_SYNC_LVL_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] ovf_cnt,
  output logic [15:0] unf_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] ptr_t;

  ptr_t wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, lvl_q, lvl_n;
  logic wr_acc, rd_acc;
  logic full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic [DATA_WIDTH-1:0] mem_rdata, rd_data_q;
  level_max_t lvl_ext, af_ext, ae_ext;

  assign wr_acc = fif.wr_en & ~full_q & ~fif.flush;
  assign rd_acc = fif.rd_en & ~empty_q & ~fif.flush;

  always_comb begin
    wr_ptr_n = wr_ptr + ptr_t'(wr_acc);
    rd_ptr_n = rd_ptr + ptr_t'(rd_acc);
    if (fif.flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end
    lvl_n = wr_ptr_n - rd_ptr_n;
  end

  assign lvl_ext = level_max_t'(lvl_n);
  assign af_ext  = level_max_t'(fif.af_thresh);
  assign ae_ext  = level_max_t'(fif.ae_thresh);

  dfifo_dpram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (fif.wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      lvl_q  <= lvl_n;
      if (fif.flush) begin
        full_q  <= 1'b0;
        empty_q <= 1'b1;
        af_q    <= 1'b0;
        ae_q    <= 1'b1;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        full_q  <= (lvl_n == ptr_t'(DEPTH));
        empty_q <= (lvl_n == '0);
        af_q    <= (lvl_ext >= af_ext);
        ae_q    <= (lvl_ext <= ae_ext);
        ovf_q   <= fif.wr_en & full_q;
        unf_q   <= fif.rd_en & empty_q;
      end
      // Standard mode keeps the last word across flushes and idle cycles.
      if (FWFT == FIFO_MODE_STD && rd_acc) rd_data_q <= mem_rdata;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign fif.rd_data = empty_q ? '0 : mem_rdata;
    end else begin : g_std
      assign fif.rd_data = rd_data_q;
    end
  endgenerate

  assign fif.full         = full_q;
  assign fif.empty        = empty_q;
  assign fif.almost_full  = af_q;
  assign fif.almost_empty = ae_q;
  assign fif.level        = lvl_q;
  assign fif.overflow     = ovf_q;
  assign fif.underflow    = unf_q;

`ifdef DFIFO_SYNC_LVL_STATS_EN
  logic [15:0] ovf_cnt_q, unf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (stat_clr) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (ovf_q && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (unf_q && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;
`endif

endmodule

// File: tb/tb_dfifo_sync_lvl.sv
// Directed bench for dfifo_sync_lvl: standard (d0) and FWFT (d1) instances share one stimulus stream.
module tb_dfifo_sync_lvl;
  import dfifo_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  // Non-zero data base so a visible word never looks like the reset value of rd_data.
  localparam logic [31:0] BASE = 32'hCAFE_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush   = 1'b0;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   af_t    = 5'd12;
  logic [AW:0]   ae_t    = 5'd2;

  int total = 0;
  int bad   = 0;

  dfifo_sync_lvl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  dfifo_sync_lvl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  assign if0.flush = flush;  assign if1.flush = flush;
  assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;
  assign if0.rd_en = rd_en;  assign if1.rd_en = rd_en;
  assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
  assign if0.af_thresh = af_t;  assign if1.af_thresh = af_t;
  assign if0.ae_thresh = ae_t;  assign if1.ae_thresh = ae_t;

`ifdef DFIFO_SYNC_LVL_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] ovf0, unf0, ovf1, unf1;
`endif

  dfifo_sync_lvl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) d0 (
    .clk (clk),
    .rst (rst),
    .fif (if0)
`ifdef DFIFO_SYNC_LVL_STATS_EN
    , .stat_clr (stat_clr), .ovf_cnt (ovf0), .unf_cnt (unf0)
`endif
  );

  dfifo_sync_lvl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) d1 (
    .clk (clk),
    .rst (rst),
    .fif (if1)
`ifdef DFIFO_SYNC_LVL_STATS_EN
    , .stat_clr (stat_clr), .ovf_cnt (ovf1), .unf_cnt (unf1)
`endif
  );

  // Status word per instance: {empty, full, almost_full, almost_empty, overflow, underflow, level}
  wire [10:0] st0 = {if0.empty, if0.full, if0.almost_full, if0.almost_empty,
                     if0.overflow, if0.underflow, if0.level};
  wire [10:0] st1 = {if1.empty, if1.full, if1.almost_full, if1.almost_empty,
                     if1.overflow, if1.underflow, if1.level};
  wire [21:0] st  = {st0, st1};

  function automatic logic [10:0] exp_st(input int lvl, input logic ovf, input logic unf);
    return {lvl == 0, lvl == DEPTH, lvl >= int'(af_t), lvl <= int'(ae_t), ovf, unf, 5'(lvl)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL reset_status got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
    total++;
    if ({if0.rd_data, if1.rd_data} !== 64'h0) begin
      bad++; $display("FAIL reset_rd_data got=%h/%h want=0", if0.rd_data, if1.rd_data);
    end
    rst = 1'b0;
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL post_reset_status got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
  endtask

  task automatic test_fill();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = BASE + 32'(i);
      cyc();
      total++;
      if (st !== {2{exp_st(i + 1, 1'b0, 1'b0)}}) begin
        bad++; $display("FAIL fill[%0d] got=%h want=%h", i, st, {2{exp_st(i + 1, 1'b0, 1'b0)}});
      end
    end
    total++;
    if (if1.rd_data !== BASE) begin
      bad++; $display("FAIL fill_fwft_head got=%h want=%h", if1.rd_data, BASE);
    end
    wr_data = BASE + 32'h55;
    cyc();
    total++;
    if (st !== {2{exp_st(16, 1'b1, 1'b0)}}) begin
      bad++; $display("FAIL overflow got=%h want=%h", st, {2{exp_st(16, 1'b1, 1'b0)}});
    end
    wr_en = 1'b0;
    cyc();
    total++;
    if (st !== {2{exp_st(16, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL overflow_end got=%h want=%h", st, {2{exp_st(16, 1'b0, 1'b0)}});
    end
  endtask

  task automatic test_drain();
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (if1.rd_data !== BASE + 32'(i)) begin
        bad++; $display("FAIL drain_fwft[%0d] got=%h want=%h", i, if1.rd_data, BASE + 32'(i));
      end
      cyc();
      total++;
      if (if0.rd_data !== BASE + 32'(i)) begin
        bad++; $display("FAIL drain_std[%0d] got=%h want=%h", i, if0.rd_data, BASE + 32'(i));
      end
      total++;
      if (st !== {2{exp_st(15 - i, 1'b0, 1'b0)}}) begin
        bad++; $display("FAIL drain_st[%0d] got=%h want=%h", i, st, {2{exp_st(15 - i, 1'b0, 1'b0)}});
      end
    end
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b1)}}) begin
      bad++; $display("FAIL underflow got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b1)}});
    end
    rd_en = 1'b0;
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || if0.rd_data !== BASE + 32'hF) begin
      bad++; $display("FAIL underflow_end got=%h rd=%h want=%h rd=%h", st, if0.rd_data,
                      {2{exp_st(0, 1'b0, 1'b0)}}, BASE + 32'hF);
    end
  endtask

  task automatic test_boundary_both();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = BASE + 32'h20 + 32'(i);
      cyc();
    end
    wr_data = BASE + 32'h99;
    rd_en = 1'b1;
    total++;
    if (if1.rd_data !== BASE + 32'h20) begin
      bad++; $display("FAIL full_both_fwft_pre got=%h want=%h", if1.rd_data, BASE + 32'h20);
    end
    cyc();
    total++;
    if (st !== {2{exp_st(15, 1'b1, 1'b0)}} || if0.rd_data !== BASE + 32'h20
        || if1.rd_data !== BASE + 32'h21) begin
      bad++; $display("FAIL full_both got=%h rd=%h/%h want=%h rd=%h/%h", st, if0.rd_data,
                      if1.rd_data, {2{exp_st(15, 1'b1, 1'b0)}}, BASE + 32'h20, BASE + 32'h21);
    end
    wr_en = 1'b0;
    repeat (15) cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || if0.rd_data !== BASE + 32'h2F) begin
      bad++; $display("FAIL full_both_drain got=%h rd=%h want=%h rd=%h", st, if0.rd_data,
                      {2{exp_st(0, 1'b0, 1'b0)}}, BASE + 32'h2F);
    end
    wr_en = 1'b1;
    wr_data = BASE + 32'h77;
    cyc();
    total++;
    if (st !== {2{exp_st(1, 1'b0, 1'b1)}} || if0.rd_data !== BASE + 32'h2F
        || if1.rd_data !== BASE + 32'h77) begin
      bad++; $display("FAIL empty_both got=%h rd=%h/%h want=%h rd=%h/%h", st, if0.rd_data,
                      if1.rd_data, {2{exp_st(1, 1'b0, 1'b1)}}, BASE + 32'h2F, BASE + 32'h77);
    end
    wr_en = 1'b0;
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || if0.rd_data !== BASE + 32'h77) begin
      bad++; $display("FAIL empty_both_read got=%h rd=%h want=%h rd=%h", st, if0.rd_data,
                      {2{exp_st(0, 1'b0, 1'b0)}}, BASE + 32'h77);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_stream();
    int wn;
    int rn;
    wn = 0;
    rn = 0;
    wr_en = 1'b1;
    repeat (8) begin
      wr_data = BASE + 32'h100 + 32'(wn);
      wn++;
      cyc();
    end
    rd_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wr_data = BASE + 32'h100 + 32'(wn);
      wn++;
      total++;
      if (if1.rd_data !== BASE + 32'h100 + 32'(rn)) begin
        bad++; $display("FAIL stream_fwft[%0d] got=%h want=%h", c, if1.rd_data, BASE + 32'h100 + 32'(rn));
      end
      cyc();
      total++;
      if (if0.rd_data !== BASE + 32'h100 + 32'(rn)) begin
        bad++; $display("FAIL stream_std[%0d] got=%h want=%h", c, if0.rd_data, BASE + 32'h100 + 32'(rn));
      end
      rn++;
      total++;
      if (st !== {2{exp_st(8, 1'b0, 1'b0)}}) begin
        bad++; $display("FAIL stream_st[%0d] got=%h want=%h", c, st, {2{exp_st(8, 1'b0, 1'b0)}});
      end
    end
    wr_en = 1'b0;
    repeat (8) cyc();
    rd_en = 1'b0;
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || if0.rd_data !== BASE + 32'h100 + 32'd47) begin
      bad++; $display("FAIL stream_tail got=%h rd=%h want=%h rd=%h", st, if0.rd_data,
                      {2{exp_st(0, 1'b0, 1'b0)}}, BASE + 32'h100 + 32'd47);
    end
  endtask

  task automatic test_flush();
    wr_en = 1'b1;
    wr_data = BASE + 32'h300;
    repeat (10) cyc();
    total++;
    if (st !== {2{exp_st(10, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL flush_pre got=%h want=%h", st, {2{exp_st(10, 1'b0, 1'b0)}});
    end
    flush = 1'b1;
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || if0.rd_data !== BASE + 32'h100 + 32'd47) begin
      bad++; $display("FAIL flush got=%h rd=%h want=%h rd=%h", st, if0.rd_data,
                      {2{exp_st(0, 1'b0, 1'b0)}}, BASE + 32'h100 + 32'd47);
    end
    flush = 1'b0;
    repeat (16) cyc();
    total++;
    if (st !== {2{exp_st(16, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL flush_refill got=%h want=%h", st, {2{exp_st(16, 1'b0, 1'b0)}});
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wr_en = 1'b0;
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL flush_full got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}}) begin
      bad++; $display("FAIL flush_after got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
  endtask

  task automatic test_thresh();
    af_t = 5'd0;
    ae_t = 5'd16;
    wr_en = 1'b1;
    wr_data = BASE + 32'h400;
    cyc();
    wr_en = 1'b0;
    total++;
    if (st !== {2{exp_st(1, 1'b0, 1'b0)}} || !if0.almost_full || !if0.almost_empty) begin
      bad++; $display("FAIL thresh_forced got=%h want=%h", st, {2{exp_st(1, 1'b0, 1'b0)}});
    end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || !if1.almost_full) begin
      bad++; $display("FAIL thresh_forced_empty got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
    af_t = 5'd12;
    ae_t = 5'd2;
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || if0.almost_full) begin
      bad++; $display("FAIL thresh_restore got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
  endtask

  task automatic test_rst_mid();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = BASE + 32'h200 + 32'(i);
      cyc();
    end
    rd_en = 1'b1;
    cyc();
    total++;
    if (if0.rd_data !== BASE + 32'h200) begin
      bad++; $display("FAIL rst_pre_rd got=%h want=%h", if0.rd_data, BASE + 32'h200);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || {if0.rd_data, if1.rd_data} !== 64'h0) begin
      bad++; $display("FAIL rst_async got=%h rd=%h/%h want=%h rd=0", st, if0.rd_data,
                      if1.rd_data, {2{exp_st(0, 1'b0, 1'b0)}});
    end
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    total++;
    if (st !== {2{exp_st(0, 1'b0, 1'b0)}} || {if0.rd_data, if1.rd_data} !== 64'h0) begin
      bad++; $display("FAIL rst_release got=%h want=%h", st, {2{exp_st(0, 1'b0, 1'b0)}});
    end
  endtask

`ifdef DFIFO_SYNC_LVL_STATS_EN
  task automatic test_stats();
    wr_en = 1'b1;
    wr_data = BASE + 32'h500;
    repeat (19) cyc();
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (18) cyc();
    rd_en = 1'b0;
    repeat (2) cyc();
    total++;
    if ({ovf0, unf0, ovf1, unf1} !== {16'd3, 16'd2, 16'd3, 16'd2}) begin
      bad++; $display("FAIL stats_count got=%0d/%0d %0d/%0d want=3/2", ovf0, unf0, ovf1, unf1);
    end
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    total++;
    if ({ovf0, unf0, ovf1, unf1} !== 64'h0) begin
      bad++; $display("FAIL stats_clr got=%h/%h %h/%h want=0", ovf0, unf0, ovf1, unf1);
    end
    force d0.ovf_cnt_q = 16'hFFFF;
    force d1.ovf_cnt_q = 16'hFFFF;
    #1;
    release d0.ovf_cnt_q;
    release d1.ovf_cnt_q;
    wr_en = 1'b1;
    repeat (17) cyc();
    wr_en = 1'b0;
    repeat (2) cyc();
    total++;
    if ({ovf0, ovf1} !== {16'hFFFF, 16'hFFFF}) begin
      bad++; $display("FAIL stats_sat got=%h/%h want=ffff", ovf0, ovf1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_boundary_both();
    test_stream();
    test_flush();
    test_thresh();
    test_rst_mid();
`ifdef DFIFO_SYNC_LVL_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
